// File: rtl/decoder_scan_ctrl.sv
// ============================================================================
// decoder_scan_ctrl
// ----------------------------------------------------------------------------
// Sequential front-end for a 3-to-8 decoder. Walks the eight decoder outputs
// in ascending order, skipping channels whose bit is cleared in a live mask,
// holds each selected channel for dwell+1 cycles and pulses frame_done when
// the scan wraps back to the lowest enabled channel.
//
// Optional feature (compile-time macro SCAN_BLANK_EN):
//   When defined, a one-cycle BLANK state with en=0 is inserted at every
//   channel change (including a same-channel wrap), so sel only moves while
//   the decoder is disabled. Not inserted on the initial load from IDLE.
//   When undefined, the BLANK state and its logic do not exist.
//
// Ports:
//   clk        in   1        rising-edge clock
//   rst        in   1        synchronous, active-high reset
//   start      in   1        level request to begin scanning (ignored if busy)
//   stop       in   1        level request to abort scanning (beats start)
//   dwell      in   DWELL_W  channel is active dwell+1 cycles; sampled on load
//   mask       in   8        bit k=1 enables channel k; sampled at selection
//   sel        out  3        registered channel index -> decoder a
//   en         out  1        registered decoder enable -> decoder en
//   busy       out  1        registered, high in every state except IDLE
//   frame_done out  1        registered one-cycle pulse on scan wrap
// ============================================================================
module decoder_scan_ctrl #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [7:0]         mask,
    output logic [2:0]         sel,
    output logic               en,
    output logic               busy,
    output logic               frame_done
);

`ifdef SCAN_BLANK_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        BLANK = 2'd2
    } state_t;
`else
    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;
`endif

    state_t             state;
    state_t             state_nxt;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] cnt_nxt;
    logic [2:0]         sel_nxt;
    logic               en_nxt;
    logic               busy_nxt;
    logic               fd_nxt;
    logic [3:0]         above;      // {found, index} of next set bit above sel

    // Index of the lowest set bit; 0 when the mask is empty (callers guard it).
    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (m[k]) begin
                idx = 3'(k);
            end
        end
        return idx;
    endfunction

    // Lowest set bit strictly above cur, with a found flag in the MSB.
    // A clear found flag means the search has to wrap.
    function automatic logic [3:0] next_above(input logic [7:0] m,
                                              input logic [2:0] cur);
        logic [3:0] r;
        r = 4'd0;
        for (int k = 7; k >= 0; k--) begin
            if (m[k] && (k > int'(cur))) begin
                r = {1'b1, 3'(k)};
            end
        end
        return r;
    endfunction

    // ---- state / output registers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sel        <= 3'd0;
            en         <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            cnt        <= '0;
        end else begin
            state      <= state_nxt;
            sel        <= sel_nxt;
            en         <= en_nxt;
            busy       <= busy_nxt;
            frame_done <= fd_nxt;
            cnt        <= cnt_nxt;
        end
    end

    // ---- next-state and next-output logic ----
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        en_nxt    = en;
        busy_nxt  = busy;
        fd_nxt    = 1'b0;           // frame_done is only ever a single pulse
        cnt_nxt   = cnt;
        above     = next_above(mask, sel);

        case (state)
            IDLE: begin
                en_nxt   = 1'b0;
                busy_nxt = 1'b0;
                // Initial load never goes through BLANK: sel was not driving
                // the decoder while en was low, so there is nothing to glitch.
                if (start && !stop && (mask != 8'd0)) begin
                    state_nxt = SCAN;
                    sel_nxt   = lowest_set(mask);
                    cnt_nxt   = dwell;
                    en_nxt    = 1'b1;
                    busy_nxt  = 1'b1;
                end
            end

            SCAN: begin
                en_nxt   = 1'b1;
                busy_nxt = 1'b1;
                if (stop) begin
                    state_nxt = IDLE;
                    sel_nxt   = 3'd0;
                    en_nxt    = 1'b0;
                    busy_nxt  = 1'b0;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - DWELL_W'(1);
                end else if (mask == 8'd0) begin
                    // Every channel was masked off during the dwell: park
                    // on the current index with the decoder disabled.
                    state_nxt = IDLE;
                    en_nxt    = 1'b0;
                    busy_nxt  = 1'b0;
                end else begin
                    if (above[3]) begin
                        sel_nxt = above[2:0];
                    end else begin
                        // Wrap, which also covers re-selecting the only
                        // enabled channel.
                        sel_nxt = lowest_set(mask);
                        fd_nxt  = 1'b1;
                    end
                    cnt_nxt = dwell;
`ifdef SCAN_BLANK_EN
                    state_nxt = BLANK;
                    en_nxt    = 1'b0;
`endif
                end
            end

`ifdef SCAN_BLANK_EN
            BLANK: begin
                // sel already holds the new channel; re-enable next cycle.
                // cnt was loaded on entry and is held here.
                busy_nxt = 1'b1;
                if (stop) begin
                    state_nxt = IDLE;
                    sel_nxt   = 3'd0;
                    en_nxt    = 1'b0;
                    busy_nxt  = 1'b0;
                end else begin
                    state_nxt = SCAN;
                    en_nxt    = 1'b1;
                end
            end
`endif

            default: begin
                state_nxt = IDLE;
                en_nxt    = 1'b0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// ============================================================================
// tb_decoder_scan_ctrl
// Directed stimulus against decoder_scan_ctrl. A cycle-level reference model
// (channel / remaining-cycles / phase, with a modular rotating search over the
// mask) is compared with the DUT outputs on every negative clock edge, and
// directed sequences pin hand-computed values.
// ============================================================================
`timescale 1ns/1ps
module tb_decoder_scan_ctrl;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic [DW-1:0] dwell;
    logic [7:0]    mask;
    logic [2:0]    sel;
    logic          en;
    logic          busy;
    logic          frame_done;

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    decoder_scan_ctrl #(.DWELL_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .dwell      (dwell),
        .mask       (mask),
        .sel        (sel),
        .en         (en),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 channel active, 2 blank cycle before a channel
    int       m_phase = 0;
    int       m_left  = 0;
    logic [2:0] e_sel  = 3'd0;
    logic       e_en   = 1'b0;
    logic       e_busy = 1'b0;
    logic       e_fd   = 1'b0;

    always @(posedge clk) begin : model
        int ph, left, ch, c;
        bit fd;
        if (rst) begin
            m_phase <= 0;
            m_left  <= 0;
            e_sel   <= 3'd0;
            e_en    <= 1'b0;
            e_busy  <= 1'b0;
            e_fd    <= 1'b0;
        end else begin
            ph = m_phase; left = m_left; ch = int'(e_sel); fd = 1'b0;
            if (m_phase == 0) begin
                if (start && !stop && mask != 0) begin
                    for (int k = 7; k >= 0; k--) if (mask[k]) ch = k;
                    left = int'(dwell); ph = 1;
                end
            end else if (stop) begin
                ph = 0; ch = 0;
            end else if (m_phase == 2) begin
                ph = 1;
            end else if (m_left > 0) begin
                left = m_left - 1;
            end else if (mask == 0) begin
                ph = 0;
            end else begin
                // rotate upward from the current channel, first enabled wins
                for (int k = 8; k >= 1; k--) begin
                    c = (int'(e_sel) + k) % 8;
                    if (mask[c]) ch = c;
                end
                fd = (ch <= int'(e_sel));
                left = int'(dwell);
`ifdef SCAN_BLANK_EN
                ph = 2;
`else
                ph = 1;
`endif
            end
            m_phase <= ph;
            m_left  <= left;
            e_sel   <= 3'(ch);
            e_en    <= (ph == 1);
            e_busy  <= (ph != 0);
            e_fd    <= fd;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_sel",  32'(sel),        32'(e_sel));
            chk("model_en",   32'(en),         32'(e_en));
            chk("model_busy", 32'(busy),       32'(e_busy));
            chk("model_fd",   32'(frame_done), 32'(e_fd));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_en",   32'(en),   0);
        chk("stop_busy", 32'(busy), 0);
        chk("stop_sel",  32'(sel),  0);
    endtask

    initial begin
        int fd_cnt;
        logic [2:0] seq3 [3];
        rst = 1'b1; start = 1'b0; stop = 1'b0; dwell = '0; mask = 8'h00;
        @(negedge clk);
        tick();
        chk_on = 1'b1;
        chk("rst_sel",  32'(sel),        0);
        chk("rst_en",   32'(en),         0);
        chk("rst_busy", 32'(busy),       0);
        chk("rst_fd",   32'(frame_done), 0);
        rst = 1'b0;
        tick();

`ifndef SCAN_BLANK_EN
        // Full mask, dwell 2: 0..7 three cycles each, wrap pulse at cycle 24.
        mask = 8'hFF; dwell = 8'd2;
        pulse_start();
        for (int i = 0; i < 25; i++) begin
            chk("t1_sel", 32'(sel), (i / 3) % 8);
            chk("t1_en",  32'(en),  1);
            chk("t1_fd",  32'(frame_done), (i == 24) ? 1 : 0);
            tick();
        end
        do_stop();
        tick();

        // Sparse mask, dwell 0: 2,5,7,2,...
        mask = 8'b1010_0100; dwell = 8'd0;
        seq3[0] = 3'd2; seq3[1] = 3'd5; seq3[2] = 3'd7;
        pulse_start();
        for (int i = 0; i < 9; i++) begin
            chk("t2_sel", 32'(sel), 32'(seq3[i % 3]));
            chk("t2_fd",  32'(frame_done), (i > 0 && i % 3 == 0) ? 1 : 0);
            tick();
        end
        do_stop();
        tick();
`else
        // Two channels, dwell 1, with blanking: en 1,1,0 / sel 0,0,1 / ...
        mask = 8'h03; dwell = 8'd1;
        pulse_start();
        for (int i = 0; i < 12; i++) begin
            chk("t3_en",  32'(en),  (i % 3 == 2) ? 0 : 1);
            chk("t3_sel", 32'(sel), ((i % 6) >= 2 && (i % 6) <= 4) ? 1 : 0);
            chk("t3_fd",  32'(frame_done), (i % 6 == 5) ? 1 : 0);
            tick();
        end
        do_stop();
        tick();
`endif

        // Single channel 4, dwell 3: four wrap pulses in 20 cycles either build.
        mask = 8'h10; dwell = 8'd3; fd_cnt = 0;
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            chk("t4_sel", 32'(sel), 4);
            if (frame_done === 1'b1) fd_cnt++;
            tick();
        end
        chk("t4_fd_count", 32'(fd_cnt), 4);
        do_stop();
        tick();

        // Mask cleared mid-dwell: channel 3 finishes, then idle holding sel=3.
        mask = 8'h08; dwell = 8'd3;
        pulse_start();
        mask = 8'h00;
        for (int i = 0; i < 4; i++) begin
            chk("t5_en_hold", 32'(en), 1);
            tick();
        end
        chk("t5_en",   32'(en),         0);
        chk("t5_busy", 32'(busy),       0);
        chk("t5_sel",  32'(sel),        3);
        chk("t5_fd",   32'(frame_done), 0);
        tick();

        // start and stop together in IDLE: nothing happens.
        mask = 8'hFF; dwell = 8'd1;
        start = 1'b1; stop = 1'b1;
        tick(); tick();
        chk("t6_busy", 32'(busy), 0);
        chk("t6_en",   32'(en),   0);
        start = 1'b0; stop = 1'b0;
        tick();

        // stop mid-dwell on channel 6.
        mask = 8'h40; dwell = 8'd5;
        pulse_start();
        chk("t7_sel6", 32'(sel), 6);
        tick();
        do_stop();
        tick();

        // Reset in the middle of a scan.
        mask = 8'hFF; dwell = 8'd1;
        pulse_start();
        repeat (5) tick();
        rst = 1'b1;
        tick();
        chk("t8_sel",  32'(sel),        0);
        chk("t8_en",   32'(en),         0);
        chk("t8_busy", 32'(busy),       0);
        chk("t8_fd",   32'(frame_done), 0);
        rst = 1'b0;
        repeat (3) tick();

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
